// File: rtl/fjk_bank_pkg.sv
// Shared definitions for the JK flip-flop bank: JK action encodings and
// the EDGE / CHAIN mode constants.
package fjk_bank_pkg;

    // Encoded as {j, k}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_act_e;

    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;
    localparam int CHAIN_OFF  = 0;
    localparam int CHAIN_ON   = 1;

endpackage

// File: rtl/fjk_cell.sv
// Single JK bit with synchronous clear/load priority over the JK tick and
// an asynchronous active-low clear. Exposes its next value for change detect.
module fjk_cell
    import fjk_bank_pkg::*;
(
    input  logic sys_clk,
    input  logic cd,
    input  logic tick_i,
    input  logic clr_i,
    input  logic ld_i,
    input  logic d_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic q_next_o
);

    logic    q_q;
    logic    q_d;
    jk_act_e act;

    always_comb begin
        act = jk_act_e'({j_i, k_i});
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (tick_i) begin
            case (act)
                JK_HOLD:   q_d = q_q;
                JK_RESET:  q_d = 1'b0;
                JK_SET:    q_d = 1'b1;
                JK_TOGGLE: q_d = ~q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge cd) begin
        if (!cd) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign q_next_o = q_d;

endmodule

// File: rtl/fjk_bank.sv
// Bank of WIDTH JK bits sharing a sampled clock-enable; optionally chained
// into a synchronous binary up-counter with a terminal-count output.
module fjk_bank
    import fjk_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EDGE  = EDGE_RISE,
    parameter int CHAIN = CHAIN_OFF
) (
    input  logic             sys_clk,
    input  logic             cd,
    input  logic             cp,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             chg
);

    logic             cp_q;
    logic             chg_q;
    logic             tick;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;

    // cp_q resets high so a cp already high at reset release is not an edge
    always_ff @(posedge sys_clk or negedge cd) begin
        if (!cd) begin
            cp_q  <= 1'b1;
            chg_q <= 1'b0;
        end else begin
            cp_q  <= cp;
            chg_q <= (q_next != q);
        end
    end

    assign tick = (EDGE == EDGE_RISE) ? (cp & ~cp_q) : cp;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if ((CHAIN == CHAIN_ON) && (gi > 0)) begin : g_chain
                // Upper counter bits toggle only when every lower bit carries
                assign j_eff[gi] = j[0] & k[0] & (&q[gi-1:0]);
                assign k_eff[gi] = j[0] & k[0] & (&q[gi-1:0]);
            end else begin : g_free
                assign j_eff[gi] = j[gi];
                assign k_eff[gi] = k[gi];
            end

            fjk_cell u_cell (
                .sys_clk  (sys_clk),
                .cd       (cd),
                .tick_i   (tick),
                .clr_i    (clr),
                .ld_i     (ld),
                .d_i      (d[gi]),
                .j_i      (j_eff[gi]),
                .k_i      (k_eff[gi]),
                .q_o      (q[gi]),
                .q_next_o (q_next[gi])
            );
        end
    endgenerate

    assign qn  = ~q;
    assign tc  = (CHAIN == CHAIN_ON) && j[0] && k[0] && (&q);
    assign chg = chg_q;

endmodule

// File: tb/tb_fjk_bank.sv
// Bench for fjk_bank: three 4-bit instances (edge/independent, level/independent,
// level/counter) driven in parallel and checked against a behavioural model.
module tb_fjk_bank;

    logic       sys_clk = 1'b0;
    logic       cd, cp, clr, ld;
    logic [3:0] j, k, d;
    logic [3:0] q_w  [3];
    logic [3:0] qn_w [3];
    logic       tc_w [3];
    logic       chg_w[3];

    int n_tests = 0;
    int n_fail  = 0;

    // Unit 0: EDGE=1 CHAIN=0, unit 1: EDGE=0 CHAIN=0, unit 2: EDGE=0 CHAIN=1
    int edg_m  [3] = '{1, 0, 0};
    int chain_m[3] = '{0, 0, 1};

    logic [3:0] mq  [3];
    logic       mchg[3];
    logic       mcp [3];

    always #5 sys_clk = ~sys_clk;

    fjk_bank #(.WIDTH(4), .EDGE(1), .CHAIN(0)) u_a (
        .sys_clk(sys_clk), .cd(cd), .cp(cp), .j(j), .k(k), .clr(clr), .ld(ld), .d(d),
        .q(q_w[0]), .qn(qn_w[0]), .tc(tc_w[0]), .chg(chg_w[0]));
    fjk_bank #(.WIDTH(4), .EDGE(0), .CHAIN(0)) u_b (
        .sys_clk(sys_clk), .cd(cd), .cp(cp), .j(j), .k(k), .clr(clr), .ld(ld), .d(d),
        .q(q_w[1]), .qn(qn_w[1]), .tc(tc_w[1]), .chg(chg_w[1]));
    fjk_bank #(.WIDTH(4), .EDGE(0), .CHAIN(1)) u_c (
        .sys_clk(sys_clk), .cd(cd), .cp(cp), .j(j), .k(k), .clr(clr), .ld(ld), .d(d),
        .q(q_w[2]), .qn(qn_w[2]), .tc(tc_w[2]), .chg(chg_w[2]));

    typedef struct {
        logic       clr;
        logic       ld;
        logic       cp;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] d;
        logic [3:0] eq;
        logic       echg;
    } vec_t;

    vec_t tbl[10];

    task automatic cmp(string name, logic [3:0] act, logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic jk_bit(logic jj, logic kk, logic cur);
        if (jj && kk) return ~cur;
        if (jj)       return 1'b1;
        if (kk)       return 1'b0;
        return cur;
    endfunction

    // Counter mode with j0=k0=1 is plain increment modulo 16
    function automatic logic [3:0] model_next(int u, logic tk);
        logic [3:0] r;
        r = mq[u];
        if (clr)      return 4'h0;
        if (ld)       return d;
        if (!tk)      return r;
        if (chain_m[u] == 1) begin
            if (j[0] && k[0]) return r + 4'd1;
            r[0] = jk_bit(j[0], k[0], r[0]);
            return r;
        end
        for (int b = 0; b < 4; b++) r[b] = jk_bit(j[b], k[b], r[b]);
        return r;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            mq[u] = 4'h0; mchg[u] = 1'b0; mcp[u] = 1'b1;
        end
    endtask

    task automatic check_all(string tag);
        logic etc;
        for (int u = 0; u < 3; u++) begin
            etc = (chain_m[u] == 1) && j[0] && k[0] && (mq[u] == 4'hF);
            cmp($sformatf("%s u%0d q", tag, u),   q_w[u],          mq[u]);
            cmp($sformatf("%s u%0d qn", tag, u),  qn_w[u],         ~mq[u]);
            cmp($sformatf("%s u%0d chg", tag, u), {3'b0, chg_w[u]}, {3'b0, mchg[u]});
            cmp($sformatf("%s u%0d tc", tag, u),  {3'b0, tc_w[u]},  {3'b0, etc});
        end
    endtask

    task automatic step(string tag);
        logic       tk;
        logic [3:0] nq;
        @(posedge sys_clk);
        for (int u = 0; u < 3; u++) begin
            if (!cd) begin
                mq[u] = 4'h0; mchg[u] = 1'b0; mcp[u] = 1'b1;
            end else begin
                tk      = (edg_m[u] == 1) ? (cp & ~mcp[u]) : cp;
                nq      = model_next(u, tk);
                mchg[u] = (nq != mq[u]);
                mq[u]   = nq;
                mcp[u]  = cp;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_in(logic c, logic l, logic p, logic [3:0] jj, logic [3:0] kk, logic [3:0] dd);
        clr = c; ld = l; cp = p; j = jj; k = kk; d = dd;
    endtask

    task automatic async_clear(string tag);
        #2 cd = 1'b0;
        model_reset();
        #1;
        check_all(tag);
    endtask

    int cnt_a, cnt_b;

    initial begin
        // {clr, ld, cp, j, k, d, expected q of unit 0, expected chg of unit 0}
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'h0,    4'h0,    4'h5, 4'h5,    1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 4'b1010, 4'b0110, 4'h0, 4'h5,    1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 4'b1010, 4'b0110, 4'h0, 4'b1011, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'b1010, 4'b0110, 4'h0, 4'b1011, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'hF,    4'hF,    4'h9, 4'h0,    1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 4'h0,    4'h0,    4'h0, 4'h0,    1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'hF,    4'hF,    4'h9, 4'h9,    1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'hF,    4'hF,    4'h0, 4'h9,    1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 4'hF,    4'hF,    4'h0, 4'h6,    1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 4'hF,    4'hF,    4'h0, 4'h6,    1'b0};

        cd = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        model_reset();
        step("reset");
        step("reset");
        cd = 1'b1;

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].clr, tbl[i].ld, tbl[i].cp, tbl[i].j, tbl[i].k, tbl[i].d);
            step($sformatf("vec%0d", i));
            cmp($sformatf("vec%0d q", i), q_w[0], tbl[i].eq);
            cmp($sformatf("vec%0d chg", i), {3'b0, chg_w[0]}, {3'b0, tbl[i].echg});
        end

        // cp held high for five cycles: one tick in edge mode, five in level mode
        set_in(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0);
        step("hold_pre");
        cnt_a = 0; cnt_b = 0;
        set_in(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i));
            cnt_a += int'(chg_w[0]);
            cnt_b += int'(chg_w[1]);
        end
        cmp("hold edge toggles", cnt_a[3:0], 4'd1);
        cmp("hold level toggles", cnt_b[3:0], 4'd5);
        cmp("hold edge q", q_w[0], 4'hF);

        // Counter: 16 level ticks from zero wrap back to zero
        set_in(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0);
        step("cnt_pre");
        set_in(1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] ev;
            ev = 4'(i);
            step($sformatf("cnt%0d", i));
            cmp($sformatf("cnt%0d q", i), q_w[2], ev);
            cmp($sformatf("cnt%0d tc", i), {3'b0, tc_w[2]}, {3'b0, ev == 4'hF});
        end

        // Asynchronous clear mid-count at 7, released with cp high
        set_in(1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h0);
        step("cd_pre");
        set_in(1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 4'h0);
        for (int i = 0; i < 7; i++) step("cd_cnt");
        cmp("cd count7", q_w[2], 4'h7);
        async_clear("cd_async");
        cmp("cd async q", q_w[2], 4'h0);
        cmp("cd async chg", {3'b0, chg_w[2]}, 4'h0);
        set_in(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hA);
        step("cd_held");
        cmp("cd held q", q_w[0], 4'h0);
        cd = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'h0);
        step("cd_release");
        cmp("cd release no tick", q_w[0], 4'h0);
        step("cd_release2");
        cmp("cd release still no tick", q_w[0], 4'h0);

        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 16) == 0, ($urandom % 8) == 0, 1'($urandom_range(0, 1)),
                   4'($urandom), 4'($urandom), 4'($urandom));
            if (($urandom % 60) == 0) begin
                async_clear($sformatf("rnd%0d_cd", i));
                step($sformatf("rnd%0d_cdlow", i));
                cd = 1'b1;
            end
            step($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
